osd_col_fetch_ctrl: RTL

Sequencer between the OSD sorter and the H-matrix column memory. It captures the sorted permutation (ascending LLR order) and issues one H-column read per slot in sorted order. Returned columns pass through a credit-controlled FIFO, then go out in order on a valid/ready stream to the elimination/re-encode engine. It owns the memory read port and generates the pass-level start/busy/done sequencing.

---
 rtl/osd_col_fetch_ctrl_if.sv | 40 ++++
 rtl/osd_col_fetch_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/osd_col_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : osd_col_fetch_ctrl_if
// Description : Bundle of the control, column-memory read port and output
//               stream signals of osd_col_fetch_ctrl.
//               master = fetch controller, slave = sorter/memory/engine side.
// Revision    : 1.0  initial release
// ============================================================================
interface osd_col_fetch_ctrl_if #(
    parameter int NUM_OF_ENTERIES = 8,
    parameter int H_ROW_SIZE      = 4
) ();
    localparam int INDEX_SIZE = $clog2(NUM_OF_ENTERIES);

    logic                                  start;
    logic [NUM_OF_ENTERIES*INDEX_SIZE-1:0] perm_in;
    logic [INDEX_SIZE-1:0]                 H_col_index;
    logic                                  mem_rd_en;
    logic [H_ROW_SIZE-1:0]                 H_col;
    logic                                  col_vld;
    logic                                  col_rdy;
    logic [H_ROW_SIZE-1:0]                 col_data;
    logic [INDEX_SIZE-1:0]                 col_idx;
    logic                                  col_last;
    logic                                  busy;
    logic                                  done;

    modport master (
        input  start, perm_in, H_col, col_rdy,
        output H_col_index, mem_rd_en, col_vld, col_data, col_idx, col_last,
               busy, done
    );

    modport slave (
        output start, perm_in, H_col, col_rdy,
        input  H_col_index, mem_rd_en, col_vld, col_data, col_idx, col_last,
               busy, done
    );
endinterface
`default_nettype wire

// File: rtl/osd_col_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : osd_col_fetch_ctrl
// Description : Captures the sorted permutation, reads one H column per slot
//               in sorted order, tags returns with their original index and
//               streams them out in order through a credit-limited FIFO.
//               Optional macro OSD_FETCH_ABORT_EN adds an abort input and a
//               FLUSH state.
// Revision    : 1.0  initial release
// ============================================================================
module osd_col_fetch_ctrl #(
    parameter int NUM_OF_ENTERIES = 8,
    parameter int H_ROW_SIZE      = 4,
    parameter int MEM_LATENCY     = 1,
    parameter int FIFO_DEPTH      = 4
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
`ifdef OSD_FETCH_ABORT_EN
    input  wire logic            abort,
`endif
    osd_col_fetch_ctrl_if.master bus
);
    localparam int INDEX_SIZE = $clog2(NUM_OF_ENTERIES);
    localparam int c_SLOT_W   = $clog2(NUM_OF_ENTERIES + 1);
    localparam int c_CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int c_PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_PERM_W   = NUM_OF_ENTERIES * INDEX_SIZE;

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_FETCH = 3'd1;
    localparam logic [2:0] c_S_DRAIN = 3'd2;
    localparam logic [2:0] c_S_DONE  = 3'd3;
`ifdef OSD_FETCH_ABORT_EN
    localparam logic [2:0] c_S_FLUSH = 3'd4;
`endif

    logic [2:0]            r_state, w_state_nxt;
    logic [c_PERM_W-1:0]   r_perm;
    logic [c_SLOT_W-1:0]   r_slot;
    logic                  r_rd_en, r_rd_last;
    logic [INDEX_SIZE-1:0] r_addr;
    logic                  r_pv [MEM_LATENCY];
    logic                  r_pl [MEM_LATENCY];
    logic [INDEX_SIZE-1:0] r_pi [MEM_LATENCY];
    logic [c_CNT_W-1:0]    r_in_flight, r_fifo_cnt;
    logic [c_PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
    logic [INDEX_SIZE-1:0] r_fi [FIFO_DEPTH];
    logic [H_ROW_SIZE-1:0] r_fd [FIFO_DEPTH];
    logic                  r_fl [FIFO_DEPTH];
    logic                  r_out_vld, r_out_last;
    logic [H_ROW_SIZE-1:0] r_out_data;
    logic [INDEX_SIZE-1:0] r_out_idx;

    logic                  w_abort, w_discard;
    logic                  w_ret_vld, w_accept, w_load, w_pop_out;
    logic                  w_fifo_pop, w_fifo_push, w_bypass;
    logic [c_CNT_W-1:0]    w_in_flight_nxt, w_fifo_cnt_nxt;
    logic [c_SLOT_W-1:0]   w_slot;
    logic [INDEX_SIZE-1:0] w_slot_idx, w_addr;
    logic [c_PERM_W-1:0]   w_perm_src;
    logic                  w_issue, w_last_slot;

`ifdef OSD_FETCH_ABORT_EN
    assign w_abort   = abort && ((r_state == c_S_FETCH) || (r_state == c_S_DRAIN));
    assign w_discard = w_abort || (r_state == c_S_FLUSH);
`else
    assign w_abort   = 1'b0;
    assign w_discard = 1'b0;
`endif

    // Return tagging, output-register load and FIFO move decisions.
    assign w_ret_vld   = r_pv[MEM_LATENCY-1];
    assign w_accept    = w_ret_vld && !w_discard;
    assign w_pop_out   = r_out_vld && bus.col_rdy;
    assign w_load      = !r_out_vld || bus.col_rdy;
    assign w_fifo_pop  = w_load && (r_fifo_cnt != '0);
    assign w_bypass    = w_load && (r_fifo_cnt == '0) && w_accept;
    assign w_fifo_push = w_accept && !w_bypass;

    assign w_in_flight_nxt = r_in_flight + c_CNT_W'(r_rd_en) - c_CNT_W'(w_ret_vld);
    assign w_fifo_cnt_nxt  = r_fifo_cnt + c_CNT_W'(w_fifo_push) - c_CNT_W'(w_fifo_pop);

    // In IDLE the slot is logically 0 and the permutation comes straight from
    // the port, so the first read can be registered on the start edge.
    assign w_slot      = (r_state == c_S_IDLE) ? '0 : r_slot;
    assign w_slot_idx  = w_slot[INDEX_SIZE-1:0];
    assign w_perm_src  = (r_state == c_S_IDLE) ? bus.perm_in : r_perm;
    assign w_addr      = w_perm_src[int'(w_slot_idx)*INDEX_SIZE +: INDEX_SIZE];
    assign w_last_slot = (w_slot == c_SLOT_W'(NUM_OF_ENTERIES - 1));
    assign w_issue     = (((r_state == c_S_IDLE) && bus.start) ||
                          ((r_state == c_S_FETCH) && !w_abort)) &&
                         (w_slot < c_SLOT_W'(NUM_OF_ENTERIES)) &&
                         (({1'b0, w_in_flight_nxt} + {1'b0, w_fifo_cnt_nxt}) <
                          (c_CNT_W+1)'(FIFO_DEPTH));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:  if (bus.start) w_state_nxt = c_S_FETCH;
            c_S_FETCH: begin
                if (w_abort)                     w_state_nxt = 3'd4;
                else if (w_issue && w_last_slot) w_state_nxt = c_S_DRAIN;
            end
            c_S_DRAIN: begin
                if (w_abort)                      w_state_nxt = 3'd4;
                else if (w_pop_out && r_out_last) w_state_nxt = c_S_DONE;
            end
            c_S_DONE:  w_state_nxt = c_S_IDLE;
`ifdef OSD_FETCH_ABORT_EN
            c_S_FLUSH: if (r_in_flight == '0) w_state_nxt = c_S_IDLE;
`endif
            default:   w_state_nxt = c_S_IDLE;
        endcase
    end

    // FSM output logic.
    always_comb begin
        bus.busy = (r_state != c_S_IDLE);
        bus.done = (r_state == c_S_DONE);
    end

    assign bus.mem_rd_en   = r_rd_en;
    assign bus.H_col_index = r_addr;
    assign bus.col_vld     = r_out_vld;
    assign bus.col_data    = r_out_data;
    assign bus.col_idx     = r_out_idx;
    assign bus.col_last    = r_out_last;

    // Read issue: registered strobe/address, slot counter and perm capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_en   <= 1'b0;
            r_rd_last <= 1'b0;
            r_addr    <= '0;
            r_slot    <= '0;
            r_perm    <= '0;
        end else begin
            r_rd_en   <= w_issue;
            r_rd_last <= w_issue && w_last_slot;
            if (w_issue) r_addr <= w_addr;
            r_slot    <= w_slot + c_SLOT_W'(w_issue);
            if ((r_state == c_S_IDLE) && bus.start) r_perm <= bus.perm_in;
        end
    end

    // Valid/index/last shift pipe aligned with the memory latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                r_pv[i] <= 1'b0;
                r_pl[i] <= 1'b0;
                r_pi[i] <= '0;
            end
        end else begin
            r_pv[0] <= r_rd_en;
            r_pl[0] <= r_rd_last;
            r_pi[0] <= r_addr;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pl[i] <= r_pl[i-1];
                r_pi[i] <= r_pi[i-1];
            end
        end
    end

    // Credit counters and FIFO pointers; abort empties the FIFO at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_flight <= '0;
            r_fifo_cnt  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
        end else begin
            r_in_flight <= w_in_flight_nxt;
            if (w_abort) begin
                r_fifo_cnt <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                r_fifo_cnt <= w_fifo_cnt_nxt;
                if (w_fifo_push)
                    r_wr_ptr <= (r_wr_ptr == c_PTR_W'(FIFO_DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
                if (w_fifo_pop)
                    r_rd_ptr <= (r_rd_ptr == c_PTR_W'(FIFO_DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;
            end
        end
    end

    // FIFO storage; contents are qualified by the count so need no reset.
    always_ff @(posedge clk) begin
        if (w_fifo_push) begin
            r_fi[r_wr_ptr] <= r_pi[MEM_LATENCY-1];
            r_fd[r_wr_ptr] <= bus.H_col;
            r_fl[r_wr_ptr] <= r_pl[MEM_LATENCY-1];
        end
    end

    // Output register: FIFO head first, otherwise bypass a fresh return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_idx  <= '0;
            r_out_last <= 1'b0;
        end else if (w_abort) begin
            r_out_vld  <= 1'b0;
        end else if (w_load) begin
            if (w_fifo_pop) begin
                r_out_vld  <= 1'b1;
                r_out_data <= r_fd[r_rd_ptr];
                r_out_idx  <= r_fi[r_rd_ptr];
                r_out_last <= r_fl[r_rd_ptr];
            end else if (w_bypass) begin
                r_out_vld  <= 1'b1;
                r_out_data <= bus.H_col;
                r_out_idx  <= r_pi[MEM_LATENCY-1];
                r_out_last <= r_pl[MEM_LATENCY-1];
            end else begin
                r_out_vld  <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire
